// File: rtl/mips_if_pcgen_pkg.sv
// Shared constants and types for the instruction-fetch PC generator.
//   MipsAddrWidth  : default fetch address width
//   MipsInstrWidth : instruction word width
//   MipsResetPc    : fetch address after reset
//   MipsNop        : word substituted for a fetch that returned a bus error
//   ifpc_state_e   : 2-bit FSM state encoding of the fetch sequencer
package mips_if_pcgen_pkg;

  localparam int unsigned MipsAddrWidth  = 32;
  localparam int unsigned MipsInstrWidth = 32;
  localparam logic [31:0] MipsResetPc    = 32'hBFC0_0000;
  localparam logic [31:0] MipsNop        = 32'h0000_0000;

  typedef enum logic [1:0] {
    StIdle = 2'd0,
    StReq  = 2'd1,
    StWait = 2'd2,
    StHold = 2'd3
  } ifpc_state_e;

endpackage

// File: rtl/mips_if_pc_sel.sv
// Combinational next-fetch-PC select.
// Priority: EX redirect > sequential after fetch error > predictor taken > pc_incr.
// Ports:
//   redirect_i / redirect_pc_i : EX correction and its target
//   err_i                      : held instruction carried a fetch error
//   prdt_taken_i / prdt_pc_i   : branch predictor result
//   pc_incr_i                  : sequential successor of the held PC
//   next_pc_o                  : selected next fetch PC
module mips_if_pc_sel #(
  parameter int unsigned ADDR_W = 32
) (
  input  logic              redirect_i,
  input  logic [ADDR_W-1:0] redirect_pc_i,
  input  logic              err_i,
  input  logic              prdt_taken_i,
  input  logic [ADDR_W-1:0] prdt_pc_i,
  input  logic [ADDR_W-1:0] pc_incr_i,
  output logic [ADDR_W-1:0] next_pc_o
);

  always_comb begin
    next_pc_o = pc_incr_i;
    if (redirect_i) begin
      next_pc_o = redirect_pc_i;
    end else if (err_i) begin
      // The word behind an errored fetch is a NOP; its prediction is meaningless.
      next_pc_o = pc_incr_i;
    end else if (prdt_taken_i) begin
      next_pc_o = prdt_pc_i;
    end
  end

endmodule

// File: rtl/mips_if_pcgen.sv
// Instruction-fetch PC generator with IF/ID holding register.
// Issues one fetch at a time, holds the returned word for the mini-decoder and
// branch predictor, then picks the next PC (redirect, prediction or sequential).
// Ports:
//   clk, rst_n                  : clock, asynchronous active-low reset
//   ifu_req_valid/ready/addr    : fetch request channel (word aligned address)
//   ifu_rsp_valid/instr/err     : fetch response, one per accepted request
//   if_valid/if_ir/if_pc/if_err : held instruction toward ID; id_ready consumes it
//   pc_incr                     : if_pc + 4 toward the predictor
//   prdt_taken/prdt_pc          : predictor result for the held instruction
//   ex_redirect/ex_redirect_pc  : EX correction, highest priority in every state
module mips_if_pcgen
  import mips_if_pcgen_pkg::*;
#(
  parameter int unsigned        ADDR_W   = MipsAddrWidth,
  parameter int unsigned        INSTR_W  = MipsInstrWidth,
  parameter logic [ADDR_W-1:0]  RESET_PC = ADDR_W'(MipsResetPc)
) (
  input  logic               clk,
  input  logic               rst_n,
  output logic               ifu_req_valid,
  input  logic               ifu_req_ready,
  output logic [ADDR_W-1:0]  ifu_req_addr,
  input  logic               ifu_rsp_valid,
  input  logic [INSTR_W-1:0] ifu_rsp_instr,
  input  logic               ifu_rsp_err,
  output logic               if_valid,
  input  logic               id_ready,
  output logic [INSTR_W-1:0] if_ir,
  output logic [ADDR_W-1:0]  if_pc,
  output logic               if_err,
  output logic [ADDR_W-1:0]  pc_incr,
  input  logic               prdt_taken,
  input  logic [ADDR_W-1:0]  prdt_pc,
  input  logic               ex_redirect,
  input  logic [ADDR_W-1:0]  ex_redirect_pc
);

  ifpc_state_e        state_q, state_d;
  logic [ADDR_W-1:0]  pc_q, pc_d;
  logic               drop_q, drop_d;
  logic               if_valid_q, if_valid_d;
  logic [INSTR_W-1:0] if_ir_q, if_ir_d;
  logic [ADDR_W-1:0]  if_pc_q, if_pc_d;
  logic               if_err_q, if_err_d;
  logic [ADDR_W-1:0]  sel_pc;
  logic               take_pc;

  assign pc_incr = if_pc_q + ADDR_W'(4);

  mips_if_pc_sel #(
    .ADDR_W (ADDR_W)
  ) u_pc_sel (
    .redirect_i    (ex_redirect),
    .redirect_pc_i (ex_redirect_pc),
    .err_i         (if_err_q),
    .prdt_taken_i  (prdt_taken),
    .prdt_pc_i     (prdt_pc),
    .pc_incr_i     (pc_incr),
    .next_pc_o     (sel_pc)
  );

  // pc_r moves on any redirect, or when ID takes the held instruction.
  assign take_pc = ex_redirect || ((state_q == StHold) && id_ready);

  always_comb begin
    state_d    = state_q;
    pc_d       = take_pc ? sel_pc : pc_q;
    drop_d     = drop_q;
    if_valid_d = if_valid_q;
    if_ir_d    = if_ir_q;
    if_pc_d    = if_pc_q;
    if_err_d   = if_err_q;

    unique case (state_q)
      StIdle: state_d = StReq;
      StReq: begin
        if (ifu_req_ready) begin
          state_d = StWait;
          // Request went out with the stale PC; its response must be thrown away.
          if (ex_redirect) drop_d = 1'b1;
        end
      end
      StWait: begin
        if (ifu_rsp_valid) begin
          if (drop_q || ex_redirect) begin
            drop_d  = 1'b0;
            state_d = StReq;
          end else begin
            if_ir_d    = ifu_rsp_err ? INSTR_W'(MipsNop) : ifu_rsp_instr;
            if_pc_d    = pc_q;
            if_err_d   = ifu_rsp_err;
            if_valid_d = 1'b1;
            state_d    = StHold;
          end
        end else if (ex_redirect) begin
          drop_d = 1'b1;
        end
      end
      StHold: begin
        if (ex_redirect || id_ready) begin
          if_valid_d = 1'b0;
          state_d    = StReq;
        end
      end
      default: state_d = StIdle;
    endcase

    if (ex_redirect) if_valid_d = 1'b0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= StIdle;
      pc_q       <= RESET_PC;
      drop_q     <= 1'b0;
      if_valid_q <= 1'b0;
      if_ir_q    <= '0;
      if_pc_q    <= '0;
      if_err_q   <= 1'b0;
    end else begin
      state_q    <= state_d;
      pc_q       <= pc_d;
      drop_q     <= drop_d;
      if_valid_q <= if_valid_d;
      if_ir_q    <= if_ir_d;
      if_pc_q    <= if_pc_d;
      if_err_q   <= if_err_d;
    end
  end

  assign ifu_req_valid = (state_q == StReq);
  assign ifu_req_addr  = {pc_q[ADDR_W-1:2], 2'b00};
  assign if_valid      = if_valid_q;
  assign if_ir         = if_ir_q;
  assign if_pc         = if_pc_q;
  assign if_err        = if_err_q;

  // A response is only legal while a request is outstanding.
  rsp_only_in_wait_a : assert property (
    @(posedge clk) disable iff (!rst_n) ifu_rsp_valid |-> (state_q == StWait)
  );

endmodule

// File: tb/tb_mips_if_pcgen.sv
// Self-checking bench for mips_if_pcgen: a randomized driver acting as memory,
// ID stage, predictor and EX, with a transaction-level model that pushes the
// expected request addresses and held instructions into queues; a monitor pops
// and compares them whenever the DUT presents a request or a held instruction.
module tb_mips_if_pcgen;

  localparam logic [31:0] RESET_PC = 32'hBFC0_0000;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        ifu_req_valid;
  logic        ifu_req_ready;
  logic [31:0] ifu_req_addr;
  logic        ifu_rsp_valid;
  logic [31:0] ifu_rsp_instr;
  logic        ifu_rsp_err;
  logic        if_valid;
  logic        id_ready;
  logic [31:0] if_ir;
  logic [31:0] if_pc;
  logic        if_err;
  logic [31:0] pc_incr;
  logic        prdt_taken;
  logic [31:0] prdt_pc;
  logic        ex_redirect;
  logic [31:0] ex_redirect_pc;

  mips_if_pcgen dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .ifu_req_valid  (ifu_req_valid),
    .ifu_req_ready  (ifu_req_ready),
    .ifu_req_addr   (ifu_req_addr),
    .ifu_rsp_valid  (ifu_rsp_valid),
    .ifu_rsp_instr  (ifu_rsp_instr),
    .ifu_rsp_err    (ifu_rsp_err),
    .if_valid       (if_valid),
    .id_ready       (id_ready),
    .if_ir          (if_ir),
    .if_pc          (if_pc),
    .if_err         (if_err),
    .pc_incr        (pc_incr),
    .prdt_taken     (prdt_taken),
    .prdt_pc        (prdt_pc),
    .ex_redirect    (ex_redirect),
    .ex_redirect_pc (ex_redirect_pc)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_chk  = 0;
  int n_fail = 0;

  function automatic void check(input string name, input logic [31:0] act,
                                input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endfunction

  // Stimulus knobs (percent probabilities).
  int unsigned ready_pct = 100, idr_pct = 100, redir_pct = 0;
  int unsigned taken_pct = 0, err_pct = 0, lat_max = 0;
  bit          mem_hold = 1'b0, fix_tgt_en = 1'b0, os_red = 1'b0;
  logic [31:0] fix_tgt = '0, os_pc = '0;

  // Reference model state.
  typedef struct {
    logic [31:0] pc;
    logic [31:0] ir;
    logic        err;
    int          vis;
  } item_t;

  item_t       out_q[$];
  logic [31:0] addr_q[$];
  logic [31:0] exp_pc = RESET_PC;
  bit          pend = 1'b0, pend_live = 1'b0;
  int          pend_cyc = 0;
  logic [31:0] pend_pc = '0;

  // Driver + model: decides this cycle's inputs and what they imply.
  always @(negedge clk) begin : drv
    bit          red, hs, hold;
    logic [31:0] rpc;
    item_t       it;
    if (!rst_n) begin
      ifu_req_ready  = 1'b0;
      ifu_rsp_valid  = 1'b0;
      ifu_rsp_instr  = '0;
      ifu_rsp_err    = 1'b0;
      id_ready       = 1'b0;
      prdt_taken     = 1'b0;
      prdt_pc        = '0;
      ex_redirect    = 1'b0;
      ex_redirect_pc = '0;
      pend           = 1'b0;
      addr_q.delete();
      out_q.delete();
      exp_pc         = RESET_PC;
    end else begin
      red = 1'b0;
      rpc = $urandom;
      if (os_red) begin
        red    = 1'b1;
        rpc    = os_pc;
        os_red = 1'b0;
      end else if ($urandom_range(99) < redir_pct) begin
        red = 1'b1;
        if ($urandom_range(3) != 0) rpc[1:0] = 2'b00;
      end
      ex_redirect    = red;
      ex_redirect_pc = rpc;
      ifu_req_ready  = $urandom_range(99) < ready_pct;
      id_ready       = $urandom_range(99) < idr_pct;
      prdt_taken     = $urandom_range(99) < taken_pct;
      prdt_pc        = fix_tgt_en ? fix_tgt : 32'($urandom);
      ifu_rsp_valid  = pend && !mem_hold && (cyc >= pend_cyc);
      ifu_rsp_instr  = $urandom;
      ifu_rsp_err    = ifu_rsp_valid && ($urandom_range(99) < err_pct);

      hold = (out_q.size() > 0) && (out_q[0].vis <= cyc);
      hs   = ifu_req_valid && ifu_req_ready;

      // A response survives only if no redirect touched its request's lifetime.
      if (ifu_rsp_valid) begin
        if (pend_live && !red) begin
          it.pc  = pend_pc;
          it.ir  = ifu_rsp_err ? 32'h0 : ifu_rsp_instr;
          it.err = ifu_rsp_err;
          it.vis = cyc + 1;
          out_q.push_back(it);
        end
        pend = 1'b0;
      end else if (pend && red) begin
        pend_live = 1'b0;
      end

      if (hs) begin
        addr_q.push_back({exp_pc[31:2], 2'b00});
        pend      = 1'b1;
        pend_live = !red;
        pend_pc   = exp_pc;
        pend_cyc  = cyc + 1 + int'($urandom_range(lat_max));
      end

      if (red) exp_pc = rpc;
      else if (hold && id_ready)
        exp_pc = (out_q[0].err || !prdt_taken) ? out_q[0].pc + 32'd4 : prdt_pc;
    end
  end

  // Monitor: compares what the DUT presents against the queued expectations.
  always @(negedge clk) begin : mon
    bit    ev;
    item_t it;
    #1;
    if (rst_n) begin
      if (ifu_req_valid && ifu_req_ready) begin
        if (addr_q.size() == 0) begin
          n_chk++;
          n_fail++;
          $display("FAIL req_unexpected: got request %h expected none", ifu_req_addr);
        end else begin
          check("req_addr", ifu_req_addr, addr_q.pop_front());
        end
      end
      ev = (out_q.size() > 0) && (out_q[0].vis <= cyc);
      check("if_valid", {31'b0, if_valid}, {31'b0, ev});
      if (ev && if_valid) begin
        it = out_q[0];
        check("if_pc", if_pc, it.pc);
        check("if_ir", if_ir, it.ir);
        check("if_err", {31'b0, if_err}, {31'b0, it.err});
        check("pc_incr", pc_incr, it.pc + 32'd4);
      end
      if (ev && id_ready && !ex_redirect) void'(out_q.pop_front());
      if (ex_redirect) out_q.delete();
    end
  end

  task automatic step(input int n);
    repeat (n) @(negedge clk);
    #2;
  endtask

  // Wait until a request (to pc, unless any) has been accepted by the memory.
  task automatic wait_pend(input bit any, input logic [31:0] pc, input int budget);
    int n = 0;
    while (!(pend && (any || pend_pc == pc)) && n < budget) begin
      step(1);
      n++;
    end
    n_chk++;
    if (!(pend && (any || pend_pc == pc))) begin
      n_fail++;
      $display("FAIL wait_req: no request to %h within %0d cycles", pc, budget);
    end
  endtask

  task automatic wait_hold(input int budget);
    int n = 0;
    while (!if_valid && n < budget) begin
      step(1);
      n++;
    end
    check("hold_reached", {31'b0, if_valid}, 32'd1);
  endtask

  task automatic redirect_to(input logic [31:0] pc);
    os_pc  = pc;
    os_red = 1'b1;
    step(1);
  endtask

  initial begin
    rst_n = 1'b0;
    step(3);
    check("rst_if_valid", {31'b0, if_valid}, 32'd0);
    check("rst_req_valid", {31'b0, ifu_req_valid}, 32'd0);
    check("rst_if_pc", if_pc, 32'd0);
    check("rst_if_ir", if_ir, 32'd0);

    // Reset release: one IDLE cycle, then the first request at RESET_PC.
    rst_n = 1'b1;
    #1;
    check("idle_req_valid", {31'b0, ifu_req_valid}, 32'd0);
    step(1);
    check("first_req_valid", {31'b0, ifu_req_valid}, 32'd1);
    check("first_req_addr", ifu_req_addr, RESET_PC);
    wait_pend(1'b0, RESET_PC + 32'd4, 20);
    step(4);

    // Predicted taken at 0x100 toward 0xF0.
    taken_pct = 100; fix_tgt_en = 1'b1; fix_tgt = 32'h0000_00F0;
    redirect_to(32'h0000_0100);
    wait_pend(1'b0, 32'h0000_00F0, 20);
    step(4);
    taken_pct = 0; fix_tgt_en = 1'b0;

    // Redirect while the fetch of 0x200 is outstanding; response 3 cycles later.
    redirect_to(32'h0000_0200);
    wait_pend(1'b0, 32'h0000_0200, 20);
    mem_hold = 1'b1;
    redirect_to(32'h0000_0400);
    step(2);
    check("drop_if_valid", {31'b0, if_valid}, 32'd0);
    mem_hold = 1'b0;
    wait_pend(1'b0, 32'h0000_0400, 20);
    step(3);

    // Back-pressure from ID for 5 cycles.
    idr_pct = 0;
    wait_hold(20);
    for (int i = 0; i < 5; i++) begin
      step(1);
      check("bp_no_req", {31'b0, ifu_req_valid}, 32'd0);
      check("bp_if_valid", {31'b0, if_valid}, 32'd1);
    end
    idr_pct = 100;
    step(4);

    // Fetch error at 0x300 forces the sequential path despite a taken prediction.
    err_pct = 100; taken_pct = 100; fix_tgt_en = 1'b1; fix_tgt = 32'h0000_0500;
    redirect_to(32'h0000_0300);
    wait_pend(1'b0, 32'h0000_0304, 20);
    step(3);
    err_pct = 0; taken_pct = 0; fix_tgt_en = 1'b0;

    // Sequential wrap at the top of the address space.
    redirect_to(32'hFFFF_FFFC);
    wait_pend(1'b0, 32'h0000_0000, 20);
    step(3);

    // Mixed random traffic.
    ready_pct = 70; idr_pct = 60; redir_pct = 8; taken_pct = 40; err_pct = 10; lat_max = 3;
    step(3000);

    // Asynchronous reset while a fetch is outstanding; the response never comes.
    redir_pct = 0;
    wait_pend(1'b1, 32'h0, 50);
    mem_hold = 1'b1;
    step(1);
    rst_n = 1'b0;
    #1;
    check("areset_if_valid", {31'b0, if_valid}, 32'd0);
    check("areset_req_valid", {31'b0, ifu_req_valid}, 32'd0);
    check("areset_if_pc", if_pc, 32'd0);
    check("areset_if_ir", if_ir, 32'd0);
    step(2);
    mem_hold = 1'b0;
    ready_pct = 100; idr_pct = 100; taken_pct = 0; err_pct = 0; lat_max = 0;
    rst_n = 1'b1;
    step(1);
    check("restart_req_addr", ifu_req_addr, RESET_PC);
    wait_pend(1'b0, RESET_PC + 32'd4, 20);
    step(10);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
